// File: rtl/ecg_nn_pkg.sv
// Shared types and helpers for the ECG network datapath.
package ecg_nn_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sign-magnitude ordering of float32 bit patterns. +0 and -0 compare equal;
  // NaN/Inf are not special-cased and simply order by their bits.
  function automatic logic fp_gt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic gt;
    unique case ({a[FP_W-1], b[FP_W-1]})
      2'b00:   gt = (a[FP_W-2:0] > b[FP_W-2:0]);
      2'b11:   gt = (a[FP_W-2:0] < b[FP_W-2:0]);
      2'b01:   gt = !((a[FP_W-2:0] == '0) && (b[FP_W-2:0] == '0));
      default: gt = 1'b0;
    endcase
    return gt;
  endfunction

endpackage

// File: rtl/layer_argmax_float_gt.sv
// Combinational float32 greater-than comparator (strict).
module float_gt
  import ecg_nn_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            gt
);

  assign gt = fp_gt(a, b);

endmodule

// File: rtl/layer_argmax.sv
// Sequential argmax over the final dense layer's float32 outputs: one
// comparison per cycle, result returned over a valid/ready handshake.
module layer_argmax
  import ecg_nn_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_NODES*FP_W-1:0] in_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_class,
  output logic [FP_W-1:0]           out_max,
  output logic                      busy
);

  // One extra counter bit so the count never wraps when NUM_NODES == 2**IDX_W.
  localparam int CNT_W = IDX_W + 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NODES - 1);

  state_e                  state_q, state_d;
  logic [FP_W-1:0]         vec_q [DEPTH];
  logic [DEPTH*FP_W-1:0]   in_pad;
  logic [FP_W-1:0]         best_val_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_class_q;
  logic [FP_W-1:0]         out_max_q;

  logic                    accept;
  logic                    scan_last;
  logic                    out_hs;
  logic [IDX_W-1:0]        cand_idx;
  logic [FP_W-1:0]         cand_val;
  logic                    cand_gt;

  // Pad the input to a power-of-two number of slots so the scan mux index is
  // always in range; unused slots load as zero and are never compared.
  assign in_pad    = (DEPTH*FP_W)'(in_vec);

  assign accept    = in_valid && (state_q == IDLE);
  assign scan_last = (cnt_q == LAST_CNT);
  assign out_hs    = out_valid_q && out_ready;
  assign cand_idx  = cnt_q[IDX_W-1:0];
  assign cand_val  = vec_q[cand_idx];

  float_gt u_gt (
    .a  (cand_val),
    .b  (best_val_q),
    .gt (cand_gt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = (NUM_NODES == 1) ? DONE : SCAN;
      SCAN:    if (scan_last) state_d = DONE;
      DONE:    if (out_hs)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Capture the whole vector at the accept edge; later in_vec changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) vec_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < DEPTH; k++) vec_q[k] <= in_pad[k*FP_W +: FP_W];
    end
  end

  // Running maximum and scan counter; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      best_val_q <= in_vec[FP_W-1:0];
      best_idx_q <= '0;
      cnt_q      <= CNT_W'(1);
    end else if (state_q == SCAN) begin
      if (cand_gt) begin
        best_val_q <= cand_val;
        best_idx_q <= cand_idx;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: published after the final compare, held until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_max_q   <= '0;
    end else if ((state_q == SCAN) && scan_last) begin
      out_valid_q <= 1'b1;
      out_class_q <= cand_gt ? cand_idx : best_idx_q;
      out_max_q   <= cand_gt ? cand_val : best_val_q;
    end else if ((state_q == DONE) && !out_valid_q) begin
      // Single-node build: nothing to scan, publish one cycle after accept.
      out_valid_q <= 1'b1;
      out_class_q <= best_idx_q;
      out_max_q   <= best_val_q;
    end else if ((state_q == DONE) && out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_layer_argmax.sv
// Scoreboard bench for layer_argmax: a 4-node build and a 1-node build.
module tb_layer_argmax;

  typedef struct {
    int          cls;
    logic [31:0] mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-node instance
  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic [127:0] in_vec4 = '0;
  logic         out_valid4;
  logic         out_ready4;
  logic [1:0]   out_class4;
  logic [31:0]  out_max4;
  logic         busy4;

  // 1-node instance
  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [31:0]  in_vec1 = '0;
  logic         out_valid1;
  logic         out_ready1 = 1'b1;
  logic [0:0]   out_class1;
  logic [31:0]  out_max1;
  logic         busy1;

  logic rdy_man  = 1'b1;
  logic rdy_rand = 1'b1;
  logic rnd_mode = 1'b0;
  assign out_ready4 = rnd_mode ? rdy_rand : rdy_man;

  layer_argmax #(.NUM_NODES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_vec(in_vec4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_class(out_class4), .out_max(out_max4), .busy(busy4)
  );

  layer_argmax #(.NUM_NODES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_vec(in_vec1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_class(out_class1), .out_max(out_max1), .busy(busy1)
  );

  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_miss = 0;
  exp_t q4[$];
  exp_t q1[$];
  int   acc4 = 0, acc1 = 0, hs4 = 0, hs1 = 0;
  logic prev_v4 = 1'b0, prev_v1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ordering: map each float to a signed integer key so that plain
  // integer comparison gives the float order (+0 and -0 both map to 0).
  function automatic longint fkey(input logic [31:0] f);
    longint mag;
    mag = longint'(f[30:0]);
    return f[31] ? -mag : mag;
  endfunction

  function automatic exp_t ref_argmax(input logic [127:0] v, input int n);
    exp_t e;
    logic [31:0] el;
    e.cls = 0;
    e.mx  = v[31:0];
    for (int i = 1; i < n; i++) begin
      el = v[i*32 +: 32];
      if (fkey(el) > fkey(e.mx)) begin
        e.cls = i;
        e.mx  = el;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    case ($urandom_range(0, 6))
      0:       r = 32'h0000_0000;
      1:       r = 32'h8000_0000;
      2:       r = 32'h3F80_0000;
      3:       r = 32'hBF80_0000;
      4:       r = {1'b0, 8'($urandom_range(120, 130)), 23'($urandom())};
      default: r = $urandom();
    endcase
    return r;
  endfunction

  // Random backpressure source.
  always @(posedge clk) begin
    #1 rdy_rand = ($urandom_range(0, 3) != 0);
  end

  // Monitor for the 4-node instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v4 = 1'b0;
    end else begin
      if (in_valid4 && in_ready4) acc4 = cyc + 1;
      if (out_valid4 && !prev_v4) check("latency4", 64'(cyc - acc4), 64'd3);
      if (out_valid4 && out_ready4) begin
        check("pending4", 64'(q4.size() > 0), 64'd1);
        if (q4.size() > 0) begin
          exp_t e;
          e = q4.pop_front();
          check("class4", 64'(out_class4), 64'(e.cls));
          check("max4", 64'(out_max4), 64'(e.mx));
        end
        hs4++;
      end
      prev_v4 = out_valid4;
    end
  end

  // Monitor for the 1-node instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v1 = 1'b0;
    end else begin
      if (in_valid1 && in_ready1) acc1 = cyc + 1;
      if (out_valid1 && !prev_v1) check("latency1", 64'(cyc - acc1), 64'd1);
      if (out_valid1 && out_ready1) begin
        check("pending1", 64'(q1.size() > 0), 64'd1);
        if (q1.size() > 0) begin
          exp_t e;
          e = q1.pop_front();
          check("class1", 64'(out_class1), 64'(e.cls));
          check("max1", 64'(out_max1), 64'(e.mx));
        end
        hs1++;
      end
      prev_v1 = out_valid1;
    end
  end

  task automatic send4(input logic [127:0] v);
    int t;
    @(posedge clk); #1;
    in_vec4   = v;
    in_valid4 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready4 && t < 100);
    check("accept4", 64'(in_ready4), 64'd1);
    q4.push_back(ref_argmax(v, 4));
    n_vec++;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_vec4   = {4{$urandom()}};
  endtask

  task automatic send1(input logic [31:0] v);
    int t;
    @(posedge clk); #1;
    in_vec1   = v;
    in_valid1 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready1 && t < 100);
    check("accept1", 64'(in_ready1), 64'd1);
    q1.push_back(ref_argmax({96'd0, v}, 1));
    n_vec++;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_vec1   = $urandom();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready4 && in_ready1 && q4.size() == 0 && q1.size() == 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_idle", 64'(in_ready4 && in_ready1 && q4.size() == 0 && q1.size() == 0), 64'd1);
  endtask

  logic [1:0]  hold_cls;
  logic [31:0] hold_max;
  int          hs_before;
  int          t;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_out_class", 64'(out_class4), 64'd0);
    check("rst_out_max", 64'(out_max4), 64'd0);
    check("rst_in_ready", 64'(in_ready4), 64'd1);
    check("rst_busy", 64'(busy4), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors: node 0 in the low word.
    send4({32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}); wait_idle();
    send4({32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000}); wait_idle();
    send4({32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000}); wait_idle();
    send4({32'hBF40_0000, 32'hC000_0000, 32'hBF00_0000, 32'hBF80_0000}); wait_idle();
    send4({32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000}); wait_idle();

    // Backpressure: result held, second in_valid ignored.
    rdy_man = 1'b0;
    send4({32'h4100_0000, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000});
    t = 0;
    while (!out_valid4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid", 64'(out_valid4), 64'd1);
    hold_cls = out_class4;
    hold_max = out_max4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid4 = 1'b1;
      in_vec4   = {4{32'h7F00_0000}};
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid4), 64'd1);
      check("bp_hold_class", 64'(out_class4), 64'(hold_cls));
      check("bp_hold_max", 64'(out_max4), 64'(hold_max));
      check("bp_in_ready", 64'(in_ready4), 64'd0);
    end
    hs_before = hs4;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    rdy_man   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_hs", 64'(hs4 - hs_before), 64'd1);
    check("bp_valid_drop", 64'(out_valid4), 64'd0);
    check("bp_in_ready_back", 64'(in_ready4), 64'd1);
    check("bp_class_kept", 64'(out_class4), 64'd3);
    repeat (10) @(negedge clk);
    check("bp_no_extra", 64'(hs4 - hs_before), 64'd1);
    wait_idle();

    // Reset in the middle of a scan.
    send4({32'h3F00_0000, 32'h4040_0000, 32'h0000_0000, 32'h3F80_0000});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid4), 64'd0);
    check("mid_rst_class", 64'(out_class4), 64'd0);
    check("mid_rst_max", 64'(out_max4), 64'd0);
    check("mid_rst_busy", 64'(busy4), 64'd0);
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready4), 64'd1);
    send4({32'h3F00_0000, 32'h4040_0000, 32'h0000_0000, 32'h3F80_0000}); wait_idle();

    // Randomized traffic with random backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send4({rand_fp(), rand_fp(), rand_fp(), rand_fp()});
      if ($urandom_range(0, 3) == 0) begin
        send4({4{rand_fp()}});
      end
    end
    wait_idle();
    rnd_mode = 1'b0;

    // Single-node build.
    send1(32'h3E5B_996A); wait_idle();
    for (int i = 0; i < 8; i++) send1(rand_fp());
    wait_idle();

    check("q4_empty", 64'(q4.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
